// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-port AXI4-lite SRAM slave for the LSU data port.
// One transaction at a time; a read wins over a write presented in the same cycle.
// Optional macro SRAM_RAND_DELAY_EN: adds an LFSR-driven response delay of 0..7 cycles.
// Without it every response comes in the cycle after the (last) handshake.
module axi_sram_slave #(
   parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
   parameter int          DEPTH_LOG2 = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int          DEPTH = 1 << DEPTH_LOG2;
   localparam logic [32:0] SPAN  = 33'd4 << DEPTH_LOG2;

   typedef enum logic [2:0] {IDLE, R_DELAY, R_RESP, W_COLLECT, W_DELAY, B_RESP} state_t;

   state_t                  state, state_d;
   logic [31:0]             mem [DEPTH];
   logic [31:0]             araddr_q, awaddr_q, wdata_q;
   logic [3:0]              wstrb_q;
   logic                    aw_got, w_got;
   logic [2:0]              delay_cnt, delay_ld;
   logic [31:0]             rdata_q;
   logic [1:0]              rresp_q, bresp_q;
   logic                    ar_hs, aw_hs, w_hs;
   logic [31:0]             rd_addr, wr_addr, wr_data, rd_off, wr_off;
   logic [3:0]              wr_strb;
   logic                    rd_hit, wr_hit, rd_load, b_enter, wr_fire;
   logic [DEPTH_LOG2-1:0]   rd_idx, wr_idx;

`ifdef SRAM_RAND_DELAY_EN
   logic [7:0] lfsr;

   // Free-running Fibonacci LFSR (taps 8,6,5,4) supplying the random delay
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lfsr <= 8'hA5;
      else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign delay_ld = lfsr[2:0];
`else
   assign delay_ld = 3'd0;
`endif

   // Address decode; offsets below ADDR_BASE wrap to large values and miss
   assign rd_addr = (state == IDLE) ? araddr : araddr_q;
   assign wr_addr = aw_got ? awaddr_q : awaddr;
   assign wr_data = w_got ? wdata_q : wdata;
   assign wr_strb = w_got ? wstrb_q : wstrb;
   assign rd_off  = rd_addr - ADDR_BASE;
   assign wr_off  = wr_addr - ADDR_BASE;
   assign rd_hit  = {1'b0, rd_off} < SPAN;
   assign wr_hit  = {1'b0, wr_off} < SPAN;
   assign rd_idx  = rd_off[DEPTH_LOG2+1:2];
   assign wr_idx  = wr_off[DEPTH_LOG2+1:2];

   // Response capture and the single memory write both happen on state entry
   assign rd_load = (state_d == R_RESP) && (state != R_RESP);
   assign b_enter = (state_d == B_RESP) && (state != B_RESP);
   assign wr_fire = rst && b_enter && wr_hit;

   assign rdata  = rdata_q;
   assign rresp  = rresp_q;
   assign bresp  = bresp_q;
   assign rvalid = (state == R_RESP);
   assign bvalid = (state == B_RESP);

   // Ready generation and next-state selection
   always_comb begin
      state_d = state;
      arready = 1'b0;
      awready = 1'b0;
      wready  = 1'b0;
      case (state)
         IDLE: begin
            arready = 1'b1;
            awready = !arvalid;
            wready  = !arvalid;
         end
         W_COLLECT: begin
            awready = !aw_got;
            wready  = !w_got;
         end
         default: ;
      endcase
      ar_hs = arvalid && arready;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      case (state)
         IDLE: begin
            if (ar_hs)               state_d = (delay_ld == 3'd0) ? R_RESP : R_DELAY;
            else if (aw_hs && w_hs)  state_d = (delay_ld == 3'd0) ? B_RESP : W_DELAY;
            else if (aw_hs || w_hs)  state_d = W_COLLECT;
         end
         R_DELAY:   if (delay_cnt == 3'd1) state_d = R_RESP;
         R_RESP:    if (rready) state_d = IDLE;
         W_COLLECT: if (aw_hs || w_hs) state_d = (delay_ld == 3'd0) ? B_RESP : W_DELAY;
         W_DELAY:   if (delay_cnt == 3'd1) state_d = B_RESP;
         B_RESP:    if (bready) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Control state: FSM, channel-accepted flags, delay counter, response registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         aw_got    <= 1'b0;
         w_got     <= 1'b0;
         delay_cnt <= 3'd0;
         rdata_q   <= 32'h0;
         rresp_q   <= 2'b00;
         bresp_q   <= 2'b00;
      end else begin
         state <= state_d;
         if (aw_hs) aw_got <= 1'b1;
         if (w_hs)  w_got  <= 1'b1;
         if (state == B_RESP && bready) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end
         if ((state_d == R_DELAY || state_d == W_DELAY) && state_d != state)
            delay_cnt <= delay_ld;
         else if (delay_cnt != 3'd0)
            delay_cnt <= delay_cnt - 3'd1;
         if (rd_load) begin
            rdata_q <= rd_hit ? mem[rd_idx] : 32'h0;
            rresp_q <= rd_hit ? 2'b00 : 2'b11;
         end
         if (b_enter) bresp_q <= wr_hit ? 2'b00 : 2'b11;
      end
   end

   // Request payload latches; only meaningful while the matching flag/state says so
   always_ff @(posedge clk) begin
      if (ar_hs) araddr_q <= araddr;
      if (aw_hs) awaddr_q <= awaddr;
      if (w_hs) begin
         wdata_q <= wdata;
         wstrb_q <= wstrb;
      end
   end

   // Byte-masked array write, once per write transaction; array has no reset
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int i = 0; i < 4; i++)
            if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
   end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001: The block SHALL have these parameters (name, default, meaning):
- ADDR_BASE, 32'h8000_0000, byte address of word 0.
- DEPTH_LOG2, 10, log2 of the number of 32-bit words.
REQ-002: The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock; all state changes on its rising edge.
- rst, in, 1, reset, asynchronous, active-low.
- araddr, in, 32, read address.
- arvalid / arready, in / out, 1 / 1, read-address handshake.
- rdata, out, 32, read data.
- rresp, out, 2, read response.
- rvalid / rready, out / in, 1 / 1, read-data handshake.
- awaddr, in, 32, write address.
- awvalid / awready, in / out, 1 / 1, write-address handshake.
- wdata, in, 32, write data.
- wstrb, in, 4, write byte strobes.
- wvalid / wready, in / out, 1 / 1, write-data handshake.
- bresp, out, 2, write response.
- bvalid / bready, out / in, 1 / 1, write-response handshake.

Function
REQ-003: The block SHALL be a single-port AXI4-lite slave that serves the LSU data port.
- Storage: 2**DEPTH_LOG2 32-bit words.
- Word index: (addr - ADDR_BASE)[DEPTH_LOG2+1:2].
- addr[1:0] SHALL be ignored; reads always return the full aligned word.
REQ-004: The block SHALL implement the states IDLE, R_DELAY, R_RESP, W_COLLECT, W_DELAY and B_RESP.
REQ-005: In IDLE the ready outputs SHALL be driven as follows.
- arready = 1.
- awready = !arvalid and wready = !arvalid, so a read wins when a read and a write are both presented in the same cycle.
REQ-006: On the IDLE AR handshake the block SHALL do the following.
- Latch araddr.
- Load the delay counter (REQ-014).
- Go to R_DELAY, or go directly to R_RESP if the loaded delay is 0.
REQ-007: In R_DELAY the counter SHALL decrement once per cycle; at 1 the block SHALL go to R_RESP.
REQ-008: In R_RESP the read response SHALL behave as follows.
- rvalid = 1; rdata and rresp hold stable until rready.
- The rvalid&&rready cycle returns the block to IDLE.
REQ-009: In IDLE, write handshakes SHALL move the block as follows.
- AW and W in the same cycle: go to W_DELAY, or B_RESP if the delay is 0.
- Only one of them: latch it and go to W_COLLECT.
REQ-010: In W_COLLECT the block SHALL assert only the ready of the channel not yet accepted; when that handshake completes it SHALL proceed as in REQ-009.
REQ-011: The memory write SHALL happen exactly once, on entry to B_RESP.
- Byte lane i is written only if wstrb[i] = 1.
- wstrb = 4'b0000 writes nothing and still responds OKAY.
REQ-012: In B_RESP the write response SHALL behave as follows.
- bvalid = 1; bresp holds stable until bready.
- The bvalid&&bready cycle returns the block to IDLE.
REQ-013: Address range handling SHALL be as follows.
- An address outside [ADDR_BASE, ADDR_BASE + 4*2**DEPTH_LOG2) SHALL give resp = 2'b11 (DECERR).
- A DECERR read returns rdata = 32'h0; a DECERR write leaves the array unchanged.
- An in-range access gives 2'b00.
REQ-014: Latency SHALL be as follows.
- Handshake in cycle N with delay d: rvalid/bvalid rise in cycle N+1+d.
- For writes, N is the later of the AW and W handshakes.
REQ-015: A new request SHALL NOT be accepted until the current response handshake completes; all ready outputs are 0 outside IDLE and W_COLLECT.

Reset
REQ-016: While rst = 0 the block SHALL be in IDLE, with the following outputs and registers:
- rvalid = bvalid = 0.
- rdata = 0, rresp = 0, bresp = 0.
- Delay counter = 0; LFSR = 8'hA5.
REQ-017: Reset during any transaction SHALL abandon it.
- No memory write occurs unless B_RESP had already been entered.
- Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-018: SRAM_RAND_DELAY_EN SHALL select the delay behaviour.
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every cycle, and the delay is loaded with lfsr[2:0] (0..7).
- Undefined: the delay is always 0, there is no LFSR logic, and the response comes in cycle N+1.

Verification
REQ-019: Macro undefined; write awaddr = 32'h8000_0010, wdata = 32'hDEAD_BEEF, wstrb = 4'hF (AW and W together); then read the same address -> bvalid and rvalid each one cycle after handshake, rdata = 32'hDEAD_BEEF, resp = 00.
REQ-020: wstrb = 4'b0101, wdata = 32'h1122_3344 over 32'hDEAD_BEEF -> read returns 32'hDE22_BE44.
REQ-021: W presented 3 cycles before AW -> W_COLLECT entered, exactly one write, bvalid once, bresp = 00.
REQ-022: arvalid and awvalid/wvalid high in the same IDLE cycle -> read served first, awready = 0 that cycle, write completes after rready.
REQ-023: Read from 32'h7FFF_FFFC and from 32'h8000_1000 (DEPTH_LOG2 = 10) -> rresp = 11, rdata = 0; a write to 32'h8000_1000 leaves word 0 unchanged.
REQ-024: Macro defined, rready held low 5 cycles, rst pulsed low mid-R_DELAY -> rvalid stays asserted with stable rdata until rready; after reset rvalid = 0, state is IDLE, and the next read is served normally.
